// File: rtl/prbs_err_led_mon_pkg.sv
// Shared types and the elaboration-time parameter check for the PRBS error LED monitor.
package prbs_led_pkg;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_WARN = 2'd1,
    ST_FAIL = 2'd2
  } chan_state_e;

  function automatic bit params_ok(input int num_ch, input int cnt_w, input int warn_th,
                                   input int fail_th, input int window);
    longint cnt_max;
    cnt_max = (longint'(1) << cnt_w) - 1;
    return (num_ch >= 1) && (num_ch <= 16) &&
           (cnt_w >= 2) && (cnt_w <= 16) &&
           (warn_th >= 1) && (warn_th < fail_th) &&
           (longint'(fail_th) <= cnt_max) &&
           (window >= 1);
  endfunction

endpackage

// File: rtl/prbs_err_led_mon_chan.sv
// One PRBS error channel: saturating counter, OK/WARN/FAIL FSM, led register and,
// when PRBS_LED_DECAY_EN is defined, an error-free window timer that auto-recovers the channel.
//
// state | meaning
// OK    | count below WARN_TH
// WARN  | WARN_TH <= count < FAIL_TH, led steady on
// FAIL  | count >= FAIL_TH, led follows blinker
module prbs_err_chan
  import prbs_led_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int WARN_TH = 3,
  parameter int FAIL_TH = 6
`ifdef PRBS_LED_DECAY_EN
  ,
  parameter int WINDOW  = 1024
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             blinker,
  input  logic             prbs_error,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       state_code,
  output logic             led,
  output logic             fail
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] WARN_C  = CNT_W'(WARN_TH);
  localparam logic [CNT_W-1:0] FAIL_C  = CNT_W'(FAIL_TH);

  chan_state_e      state_q;
  chan_state_e      state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             led_q;
  logic             fail_q;

`ifdef PRBS_LED_DECAY_EN
  localparam int            TW       = $clog2(WINDOW + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(WINDOW - 1);

  logic [TW-1:0] tmr_q;
  logic [TW-1:0] tmr_nxt;
  logic          decay_hit;
`endif

  always_comb begin
    cnt_nxt = cnt_q;
    if (prbs_error && (cnt_q != CNT_MAX)) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
`ifdef PRBS_LED_DECAY_EN
    // The timer holds the number of error-free edges seen so far; the edge that
    // would make it WINDOW recovers the channel instead.
    decay_hit = !prbs_error && (tmr_q == TMR_LAST);
    tmr_nxt   = tmr_q + TW'(1);
    if (prbs_error || decay_hit || clear) begin
      tmr_nxt = '0;
    end
    if (decay_hit) begin
      cnt_nxt = '0;
    end
`endif
    if (clear) begin
      cnt_nxt = '0;
    end

    if (cnt_nxt >= FAIL_C) begin
      state_nxt = ST_FAIL;
    end else if (cnt_nxt >= WARN_C) begin
      state_nxt = ST_WARN;
    end else begin
      state_nxt = ST_OK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= ST_OK;
      led_q   <= 1'b0;
      fail_q  <= 1'b0;
`ifdef PRBS_LED_DECAY_EN
      tmr_q   <= '0;
`endif
    end else begin
      cnt_q   <= cnt_nxt;
      state_q <= state_nxt;
      // led and fail lag the state register by one edge
      led_q   <= (state_q == ST_WARN) || ((state_q == ST_FAIL) && blinker);
      fail_q  <= (state_q == ST_FAIL);
`ifdef PRBS_LED_DECAY_EN
      tmr_q   <= tmr_nxt;
`endif
    end
  end

  assign cnt        = cnt_q;
  assign state_code = state_q;
  assign led        = led_q;
  assign fail       = fail_q;

endmodule

// File: rtl/prbs_err_led_mon.sv
// Multi-channel PRBS error LED monitor: per-channel instances, output packing, any_fail OR.
// Define PRBS_LED_DECAY_EN to build in the per-channel error-free auto-recovery timer.
module prbs_err_led_mon
  import prbs_led_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 4,
  parameter int WARN_TH = 3,
  parameter int FAIL_TH = 6,
  parameter int WINDOW  = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    blinker,
  input  logic [NUM_CH-1:0]       prbs_error,
  output logic [NUM_CH-1:0]       led,
  output logic [NUM_CH*CNT_W-1:0] err_cnt,
  output logic [2*NUM_CH-1:0]     ch_state,
  output logic                    any_fail
);

  if (!params_ok(NUM_CH, CNT_W, WARN_TH, FAIL_TH, WINDOW)) begin : g_param_err
    $error("prbs_err_led_mon: illegal parameters (need 1<=WARN_TH<FAIL_TH<=2^CNT_W-1)");
  end

  logic [NUM_CH-1:0] fail_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    prbs_err_chan #(
      .CNT_W   (CNT_W),
      .WARN_TH (WARN_TH),
      .FAIL_TH (FAIL_TH)
`ifdef PRBS_LED_DECAY_EN
      ,
      .WINDOW  (WINDOW)
`endif
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .blinker    (blinker),
      .prbs_error (prbs_error[i]),
      .cnt        (err_cnt[i*CNT_W +: CNT_W]),
      .state_code (ch_state[2*i +: 2]),
      .led        (led[i]),
      .fail       (fail_vec[i])
    );
  end

  // fail_vec bits are registered, so any_fail stays aligned with led
  assign any_fail = |fail_vec;

endmodule
